// File: rtl/fft_frame_streamer.sv
// Streams one frame of real ROM samples into an FFT core as {imag=0, real} words,
// sending a single config word first and marking the end of every row with m_tlast.
module fft_frame_streamer #(
  parameter int          N_PTS    = 128,
  parameter int          N_ROWS   = 128,
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] CFG_WORD = 16'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_dout,
  output logic [15:0]         cfg_tdata,
  output logic                cfg_tvalid,
  input  logic                cfg_tready,
  output logic [2*DATA_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  input  logic                ev_tlast_missing,
  input  logic                ev_tlast_unexpected,
  output logic                frame_err
);

  localparam int                TOTAL    = N_PTS * N_ROWS;
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TOTAL - 1);
  localparam int                COL_W    = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_PTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              err_q, err_d;

  logic       start_ok;
  logic       pop;
  logic       rd_en;
  logic       last_rd;
  logic       last_pop;
  logic [2:0] credit;

  // A slot freed by this cycle's pop may be re-issued at once; this keeps
  // one read per cycle flowing while occupancy plus in-flight never exceeds 2.
  assign start_ok = (state_q == S_IDLE) && start;
  assign pop      = (fifo_cnt_q != 2'd0) && m_tready;
  assign credit   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign rd_en    = (state_q == S_STREAM) &&
                    ((credit < 3'd2) || ((credit == 3'd2) && pop));
  assign last_rd  = rd_en && (rd_cnt_q == LAST_IDX);
  assign last_pop = pop && (out_cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, otherwise a missed branch silently infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)      state_d = S_CONFIG;
      S_CONFIG: if (cfg_tready) state_d = S_STREAM;
      S_STREAM: if (last_rd)    state_d = S_DRAIN;
      S_DRAIN:  if (last_pop)   state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    cfg_tvalid = 1'b0;
    unique case (state_q)
      S_CONFIG: begin
        busy       = 1'b1;
        cfg_tvalid = 1'b1;
      end
      S_STREAM: busy = 1'b1;
      S_DRAIN:  busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next-state: read issue, skid FIFO, output indexing, error flag
  always_comb begin
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    col_d      = col_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    err_d      = err_q;
    inflight_d = rd_en;

    if (start_ok) begin
      addr_d    = '0;
      rd_cnt_d  = '0;
      out_cnt_d = '0;
      col_d     = '0;
      err_d     = 1'b0;
    end

    // rom_addr parks on the final address rather than wrapping past it
    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (!last_rd) addr_d = addr_q + 1'b1;
    end

    if (inflight_q) begin
      fifo_d[wr_ptr_q] = rom_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_cnt_d = out_cnt_q + 1'b1;
      col_d     = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end

    unique case ({inflight_q, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (busy && (ev_tlast_missing || ev_tlast_unexpected)) err_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      // NOTE: the FIFO storage is reset too because its head drives m_tdata,
      // which must read 0 out of reset; larger memories are normally left unreset.
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr  = addr_q;
  assign cfg_tdata = CFG_WORD;
  assign m_tvalid  = (fifo_cnt_q != 2'd0);
  assign m_tdata   = {{DATA_W{1'b0}}, fifo_q[rd_ptr_q]};
  assign m_tlast   = m_tvalid && (col_q == COL_LAST);
  assign frame_err = err_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Randomised scoreboard bench for fft_frame_streamer: whole-frame expectations are
// queued at each start and a monitor pops one entry per output handshake.
module tb_fft_frame_streamer;

  localparam int          N_PTS  = 128;
  localparam int          N_ROWS = 128;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 14;
  localparam int          TOTAL  = N_PTS * N_ROWS;
  localparam logic [15:0] CFG    = 16'h1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_dout = '0;
  logic [15:0]         cfg_tdata;
  logic                cfg_tvalid;
  logic                cfg_tready;
  logic [2*DATA_W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tready = 1'b1;
  logic                m_tlast;
  logic                ev_tlast_missing;
  logic                ev_tlast_unexpected;
  logic                frame_err;

  fft_frame_streamer #(
    .N_PTS(N_PTS), .N_ROWS(N_ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CFG_WORD(CFG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .ev_tlast_missing(ev_tlast_missing), .ev_tlast_unexpected(ev_tlast_unexpected),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*DATA_W-1:0] data;
    logic                last;
  } exp_t;

  exp_t              sb_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_xfer   = 0;
  int                cfg_xfers = 0;
  int                done_cnt = 0;
  int                cyc      = 0;
  int                cyc_start = 0;
  bit                rand_ready = 1'b0;
  logic [DATA_W-1:0] rom_xor = '0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous ROM, content k ^ rom_xor, one cycle read latency
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_dout <= DATA_W'(rom_addr) ^ rom_xor;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model: the whole frame as the FFT should receive it
  task automatic push_frame(input logic [DATA_W-1:0] x);
    exp_t e;
    for (int i = 0; i < TOTAL; i++) begin
      e.data = {{DATA_W{1'b0}}, DATA_W'(i) ^ x};
      e.last = ((i % N_PTS) == N_PTS - 1);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per handshake, checks stall stability
  logic [2*DATA_W-1:0] prev_data;
  logic                prev_last;
  bit                  stalled = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled)
        check(m_tvalid && (m_tdata == prev_data) && (m_tlast == prev_last),
              "stall_hold", {m_tvalid, m_tdata}, {1'b1, prev_data});
      if (m_tvalid && m_tready) begin
        n_xfer++;
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_sample", m_tdata, 0);
        end else begin
          e = sb_q.pop_front();
          check(m_tdata == e.data, "m_tdata", m_tdata, e.data);
          check(m_tlast == e.last, "m_tlast", m_tlast, e.last);
        end
      end
      if (cfg_tvalid && cfg_tready) begin
        cfg_xfers++;
        check(cfg_tdata == CFG, "cfg_tdata", cfg_tdata, CFG);
      end
      if (done) done_cnt++;
      stalled   = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end
  end

  task automatic check_reset(input string tag);
    check(busy == 1'b0,       {tag, "_busy"},       busy, 0);
    check(done == 1'b0,       {tag, "_done"},       done, 0);
    check(cfg_tvalid == 1'b0, {tag, "_cfg_tvalid"}, cfg_tvalid, 0);
    check(m_tvalid == 1'b0,   {tag, "_m_tvalid"},   m_tvalid, 0);
    check(m_tlast == 1'b0,    {tag, "_m_tlast"},    m_tlast, 0);
    check(rom_addr == '0,     {tag, "_rom_addr"},   rom_addr, 0);
    check(frame_err == 1'b0,  {tag, "_frame_err"},  frame_err, 0);
    check(m_tdata == '0,      {tag, "_m_tdata"},    m_tdata, 0);
    check(cfg_tdata == CFG,   {tag, "_cfg_tdata"},  cfg_tdata, CFG);
  endtask

  task automatic start_frame(input logic [DATA_W-1:0] x);
    @(posedge clk);
    #1;
    rom_xor   = x;
    n_xfer    = 0;
    cfg_xfers = 0;
    push_frame(x);
    start = 1'b1;
    @(posedge clk);
    cyc_start = cyc;
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - cyc_start;
        break;
      end
    end
    check(lat > 0, "done_timeout", lat, limit);
  endtask

  task automatic end_frame_checks(input int exp_done);
    check(busy == 1'b0, "busy_in_done", busy, 0);
    @(negedge clk);
    check(done == 1'b0 && busy == 1'b0, "done_one_cycle", {done, busy}, 0);
    check(sb_q.size() == 0, "samples_left", sb_q.size(), 0);
    check(n_xfer == TOTAL, "sample_count", n_xfer, TOTAL);
    check(cfg_xfers == 1, "cfg_count", cfg_xfers, 1);
    check(done_cnt == exp_done, "done_count", done_cnt, exp_done);
  endtask

  initial begin
    int lat;
    int prev_done;
    rst = 1'b1; start = 1'b0; cfg_tready = 1'b1;
    ev_tlast_missing = 1'b0; ev_tlast_unexpected = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Frame 1: ROM[k]=k, always ready, latency bound
    start_frame('0);
    wait_done(TOTAL + 20, lat);
    check(lat >= TOTAL && lat <= TOTAL + 6, "frame_latency", lat, TOTAL + 6);
    end_frame_checks(1);
    check(rom_addr == ADDR_W'(TOTAL - 1), "rom_addr_hold", rom_addr, TOTAL - 1);

    // Frame 2: config stall then 50% random m_tready
    cfg_tready = 1'b0;
    rand_ready = 1'b1;
    start_frame(16'($urandom));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(cfg_tvalid && !m_tvalid && rom_addr == '0 && busy,
            "cfg_stall", {cfg_tvalid, m_tvalid, busy}, 3'b101);
    end
    @(posedge clk);
    #1 cfg_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(cfg_tvalid == 1'b0, "cfg_tvalid_drop", cfg_tvalid, 0);
    wait_done(3 * TOTAL, lat);
    end_frame_checks(2);
    rand_ready = 1'b0;

    // Frame 3: reset after 5000 samples abandons the frame
    start_frame(16'($urandom));
    for (int i = 0; i < 6000 && n_xfer < 5000; i++) begin
      @(negedge clk);
      #2;
    end
    check(n_xfer >= 5000, "abort_point", n_xfer, 5000);
    prev_done = done_cnt;
    #1 rst = 1'b1;
    #1 check_reset("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check(done_cnt == prev_done && !busy, "no_done_after_abort", done_cnt, prev_done);

    // Frame 4: ignored start and event strobe mid-frame, restart from address 0
    start_frame(16'($urandom));
    repeat (3000) @(negedge clk);
    check(busy == 1'b1, "busy_mid_frame", busy, 1);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5000) @(negedge clk);
    check(frame_err == 1'b0, "frame_err_clear", frame_err, 0);
    @(posedge clk);
    #1 ev_tlast_missing = 1'b1;
    @(posedge clk);
    #1 ev_tlast_missing = 1'b0;
    @(negedge clk);
    check(frame_err == 1'b1, "frame_err_set", frame_err, 1);
    wait_done(TOTAL + 20, lat);
    end_frame_checks(prev_done + 1);
    repeat (5) @(negedge clk);
    check(frame_err == 1'b1 && busy == 1'b0, "frame_err_sticky", frame_err, 1);

    // Next accepted start clears the sticky error
    start_frame(16'($urandom));
    @(negedge clk);
    check(frame_err == 1'b0 && cfg_tvalid == 1'b1, "frame_err_restart", {frame_err, cfg_tvalid}, 2'b01);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Event strobe while idle must not set the error
    @(posedge clk);
    #1 ev_tlast_unexpected = 1'b1;
    @(posedge clk);
    #1 ev_tlast_unexpected = 1'b0;
    @(negedge clk);
    check(frame_err == 1'b0, "idle_event_ignored", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
